grf_wb_arbiter: RTL and testbench
=================================

Name: grf_wb_arbiter

Overview:
- Owns the single GRF write port and shares it between two writers: the pipeline W stage and the multi-cycle multiply/divide unit (MDU) result path.
- Fixed pipeline priority, with an anti-starvation counter that forces an MDU write and stalls the pipeline when the MDU has waited too long.
- Keeps a 32-bit pending-destination scoreboard for the single outstanding MDU op and raises a read-hazard stall to the decode stage.
- Sits between the W-stage / MDU outputs and the GRF WE/A3/WD/PC inputs.

Parameters:
- MAX_WAIT, 4, consecutive denied MDU cycles before forced grant; legal range 1..15; counter is 4 bits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- pipe_we  in  1  W-stage write request
- pipe_a3  in  5  W-stage destination
- pipe_wd  in  32  W-stage write data
- pipe_pc  in  32  W-stage PC
- mdu_issue  in  1  MDU op issued this cycle (1-cycle pulse)
- mdu_issue_a3  in  5  destination of the issued MDU op
- mdu_valid  in  1  MDU result ready to write
- mdu_ready  out  1  MDU result accepted this cycle (combinational)
- mdu_a3  in  5  MDU destination
- mdu_wd  in  32  MDU result
- mdu_pc  in  32  PC of the MDU op
- rd_a1  in  5  decode source register 1
- rd_a2  in  5  decode source register 2
- rd_a3  in  5  decode destination
- rd_we  in  1  decode instruction writes rd_a3
- hazard_stall  out  1  decode must stall (combinational)
- force_stall  out  1  W stage must hold; its write is dropped this cycle (combinational)
- mdu_busy  out  1  MDU op outstanding (registered)
- grf_we  out  1  GRF write enable (registered)
- grf_a3  out  5  GRF write address (registered)
- grf_wd  out  32  GRF write data (registered)
- grf_pc  out  32  GRF PC (registered)

Behaviour:
- Reset (reset==0, async):
  - grf_we/a3/wd/pc = 0, mdu_busy = 0, pending = 0, wait counter = 0, state = IDLE.
  - Reset mid-operation discards any in-flight MDU op.
- States: IDLE, WAIT, FORCE.
- "Pipe needs port" = pipe_we && pipe_a3 != 0.
- mdu_ready:
  - IDLE/WAIT: mdu_valid && !(pipe needs port).
  - FORCE: mdu_valid.
- force_stall = (state == FORCE). In FORCE, pipe_we is ignored; the pipeline holds pipe_* and retries next cycle.
- Transitions:
  - IDLE -> WAIT: mdu_valid && !mdu_ready; counter = 1.
  - WAIT: each further denied cycle increments the counter. When the counter == MAX_WAIT and the MDU is denied again, go to FORCE.
  - Any handshake (mdu_valid && mdu_ready) -> IDLE, counter = 0.
  - MAX_WAIT = 1: the first denied cycle still enters WAIT; the next denied cycle enters FORCE.
- Write register, updated every posedge:
  - MDU handshake: grf_* <= {mdu_a3 != 0, mdu_a3, mdu_wd, mdu_pc}.
  - Else if pipe needs port and state != FORCE: grf_* <= {1, pipe_a3, pipe_wd, pipe_pc}.
  - Else: grf_we <= 0; a3/wd/pc hold.
  - Latency is 1 cycle from accept to grf_we; the GRF commits at the following edge.
- Writes to $0:
  - A pipeline write to $0 never occupies the port, so the MDU may be granted that cycle.
  - An MDU write to $0 is accepted with grf_we = 0.
- Scoreboard:
  - mdu_issue while !mdu_busy: set pending[mdu_issue_a3] (unless it is $0), mdu_busy <= 1.
  - mdu_issue while mdu_busy: ignored.
  - pending bit and mdu_busy clear at the edge after the MDU handshake, i.e. the edge where the registered MDU write commits into the GRF.
  - An MDU handshake with no outstanding op still writes the GRF and leaves the scoreboard unchanged.
- hazard_stall = (rd_a1 != 0 && pending[rd_a1]) || (rd_a2 != 0 && pending[rd_a2]) || (rd_we && rd_a3 != 0 && pending[rd_a3]). This covers RAW and WAW against the in-flight MDU op.
- Simultaneous mdu_issue and clear of the same register: the set wins.
- The MDU must hold mdu_a3/wd/pc stable while mdu_valid && !mdu_ready.

Test Plan:
- Reset low mid-WAIT with counter = 3 -> all outputs 0, state IDLE, pending 0; after release, mdu_valid=1 with pipe_we=0 -> mdu_ready=1 immediately.
- mdu_issue a3=5; mdu_valid wd=0x1234 two cycles later with pipe idle -> grf_we=1, a3=5, wd=0x00001234 next cycle; hazard_stall for rd_a1=5 stays high until that GRF commit edge, then 0.
- MAX_WAIT=4; pipe_we=1, a3=3 every cycle; mdu_valid held -> mdu_ready=0 for 5 cycles, then FORCE: force_stall=1, mdu_ready=1, MDU written; next cycle the pipe write to $3 proceeds.
- pipe_we=1, a3=0 concurrent with mdu_valid a3=7 -> MDU granted the same cycle; grf_a3=7, no $0 write.
- mdu_issue a3=9 while mdu_busy -> ignored; pending[9]=0; rd_we=1, rd_a3=9 gives no stall.
- mdu_issue a3=0 -> mdu_busy=1, no pending bit; rd_a1=0 gives hazard_stall=0.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline W stage vs. MDU result path, with anti-starvation
// forcing and a single-op pending-destination scoreboard for decode hazards.
module grf_wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_a3,
  input  logic [31:0] pipe_wd,
  input  logic [31:0] pipe_pc,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_a3,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_a3,
  input  logic [31:0] mdu_wd,
  input  logic [31:0] mdu_pc,
  input  logic [4:0]  rd_a1,
  input  logic [4:0]  rd_a2,
  input  logic [4:0]  rd_a3,
  input  logic        rd_we,
  output logic        hazard_stall,
  output logic        force_stall,
  output logic        mdu_busy,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc
);

  // state | meaning
  // IDLE  | no MDU result waiting, or it was granted immediately
  // WAIT  | MDU result denied; wait_cnt counts denied cycles
  // FORCE | MDU has starved; it owns the port and the W stage holds
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0] pending, pending_nxt;
  logic        commit;
  logic        pipe_needs;
  logic        mdu_hs;
  logic        busy_eff;
  logic        issue_acc;

  assign pipe_needs = pipe_we && (pipe_a3 != 5'd0);
  assign mdu_hs     = mdu_valid && mdu_ready;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mdu_ready    = mdu_valid && !pipe_needs;
    force_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (mdu_valid && !mdu_ready) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = 4'd1;
        end
      end
      WAIT: begin
        if (!mdu_valid) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 4'd0;
        end else if (!mdu_ready) begin
          if (wait_cnt == MAX_WAIT_C) state_nxt = FORCE;
          else wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      FORCE: begin
        mdu_ready   = mdu_valid;
        force_stall = 1'b1;
        if (!mdu_valid) begin
          state_nxt    = IDLE;
          wait_cnt_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
    if (mdu_valid && mdu_ready) begin
      state_nxt    = IDLE;
      wait_cnt_nxt = 4'd0;
    end
  end

  // The outstanding op retires one edge after its handshake, so a new issue is
  // already acceptable in the retiring cycle and its set overrides the clear.
  assign busy_eff  = mdu_busy && !commit;
  assign issue_acc = mdu_issue && !busy_eff;

  always_comb begin
    pending_nxt = commit ? 32'd0 : pending;
    if (issue_acc && (mdu_issue_a3 != 5'd0)) pending_nxt[mdu_issue_a3] = 1'b1;
  end

  assign hazard_stall = ((rd_a1 != 5'd0) && pending[rd_a1]) ||
                        ((rd_a2 != 5'd0) && pending[rd_a2]) ||
                        (rd_we && (rd_a3 != 5'd0) && pending[rd_a3]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      pending  <= 32'd0;
      commit   <= 1'b0;
      mdu_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      pending  <= pending_nxt;
      commit   <= mdu_hs && busy_eff;
      if (issue_acc)   mdu_busy <= 1'b1;
      else if (commit) mdu_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we <= 1'b0;
      grf_a3 <= 5'd0;
      grf_wd <= 32'd0;
      grf_pc <= 32'd0;
    end else if (mdu_hs) begin
      grf_we <= (mdu_a3 != 5'd0);
      grf_a3 <= mdu_a3;
      grf_wd <= mdu_wd;
      grf_pc <= mdu_pc;
    end else if (pipe_needs && (state != FORCE)) begin
      grf_we <= 1'b1;
      grf_a3 <= pipe_a3;
      grf_wd <= pipe_wd;
      grf_pc <= pipe_pc;
    end else begin
      grf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed table, hand sequences for reset/scoreboard,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_grf_wb_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_a3;
  logic [31:0] pipe_wd, pipe_pc;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_a3;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_a3;
  logic [31:0] mdu_wd, mdu_pc;
  logic [4:0]  rd_a1, rd_a2, rd_a3;
  logic        rd_we;
  logic        hazard_stall, force_stall, mdu_busy;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc;

  int total = 0;
  int bad   = 0;

  grf_wb_arbiter #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
    .mdu_issue(mdu_issue), .mdu_issue_a3(mdu_issue_a3),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_a3(mdu_a3), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
    .rd_a1(rd_a1), .rd_a2(rd_a2), .rd_a3(rd_a3), .rd_we(rd_we),
    .hazard_stall(hazard_stall), .force_stall(force_stall), .mdu_busy(mdu_busy),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
    mdu_issue = 0; mdu_issue_a3 = 0;
    mdu_valid = 0; mdu_a3 = 0; mdu_wd = 0; mdu_pc = 0;
    rd_a1 = 0; rd_a2 = 0; rd_a3 = 0; rd_we = 0;
  endtask

  typedef struct {
    logic       pwe;
    logic [4:0] pa3;
    logic       mv;
    logic [4:0] ma3;
    logic       e_rdy;
    logic       e_frc;
    logic       e_we;
    logic [4:0] e_a3;
  } vec_t;

  vec_t vecs[12];

  // behavioural model state
  int          m_denied;
  bit          m_pend[32];
  bit          m_out;
  bit          m_retire_due;
  logic [4:0]  m_op_a3;
  logic        m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd, m_pc;

  initial begin
    logic e_rdy, e_frc, e_haz, needs, hs, retire_now, acc, drop;

    vecs[0]  = '{1'b1, 5'd3,  1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[1]  = '{1'b1, 5'd3,  1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[2]  = '{1'b1, 5'd3,  1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[3]  = '{1'b1, 5'd3,  1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[4]  = '{1'b1, 5'd3,  1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[5]  = '{1'b1, 5'd3,  1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7};
    vecs[6]  = '{1'b1, 5'd3,  1'b0, 5'd7, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[7]  = '{1'b1, 5'd0,  1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7};
    vecs[8]  = '{1'b0, 5'd0,  1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0};
    vecs[9]  = '{1'b0, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[10] = '{1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd12};
    vecs[11] = '{1'b1, 5'd0,  1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd12};

    idle_inputs();
    reset = 0;
    repeat (2) @(negedge clk);
    mdu_valid = 1; rd_a1 = 5;
    #1;
    chk("rst_grf_we", grf_we, 0);
    chk("rst_grf_a3", grf_a3, 0);
    chk("rst_grf_wd", grf_wd, 0);
    chk("rst_grf_pc", grf_pc, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_force", force_stall, 0);
    chk("rst_hazard", hazard_stall, 0);
    chk("rst_ready", mdu_ready, 1);
    @(negedge clk);
    idle_inputs();
    reset = 1;

    // reset in the middle of WAIT (counter 3) with an op outstanding
    @(negedge clk);
    mdu_issue = 1; mdu_issue_a3 = 6;
    tick();
    chk("pre_busy", mdu_busy, 1);
    @(negedge clk);
    mdu_issue = 0;
    pipe_we = 1; pipe_a3 = 3; pipe_wd = 32'h55; mdu_valid = 1; mdu_a3 = 7;
    repeat (3) tick();
    @(negedge clk);
    reset = 0; rd_a1 = 6;
    #1;
    chk("midrst_grf_we", grf_we, 0);
    chk("midrst_grf_a3", grf_a3, 0);
    chk("midrst_busy", mdu_busy, 0);
    chk("midrst_hazard", hazard_stall, 0);
    chk("midrst_force", force_stall, 0);
    pipe_we = 0;
    #1;
    chk("midrst_ready", mdu_ready, 1);
    @(negedge clk);
    reset = 1;
    #1;
    chk("post_rst_ready", mdu_ready, 1);
    pipe_we = 1;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk($sformatf("starve_force_%0d", k), force_stall, (k == 6));
      chk($sformatf("starve_ready_%0d", k), mdu_ready, (k == 6));
      @(negedge clk);
    end
    idle_inputs();

    // directed table: starvation, $0 handling, write register hold
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      pipe_we = vecs[i].pwe; pipe_a3 = vecs[i].pa3; pipe_wd = 32'h5555_0000 + i;
      mdu_valid = vecs[i].mv; mdu_a3 = vecs[i].ma3; mdu_wd = 32'hAAAA_0000 + i;
      #1;
      chk($sformatf("tbl%0d_ready", i), mdu_ready, vecs[i].e_rdy);
      chk($sformatf("tbl%0d_force", i), force_stall, vecs[i].e_frc);
      tick();
      chk($sformatf("tbl%0d_grf_we", i), grf_we, vecs[i].e_we);
      chk($sformatf("tbl%0d_grf_a3", i), grf_a3, vecs[i].e_a3);
    end
    @(negedge clk);
    idle_inputs();

    // scoreboard: RAW hazard held until the GRF commit edge
    @(negedge clk);
    mdu_issue = 1; mdu_issue_a3 = 5; rd_a1 = 5;
    #1 chk("sb_haz_before_issue", hazard_stall, 0);
    tick();
    chk("sb_busy_set", mdu_busy, 1);
    @(negedge clk);
    mdu_issue = 0;
    #1 chk("sb_haz_pending", hazard_stall, 1);
    @(negedge clk);
    mdu_valid = 1; mdu_a3 = 5; mdu_wd = 32'h1234; mdu_pc = 32'h400;
    #1 chk("sb_ready", mdu_ready, 1);
    tick();
    chk("sb_grf_we", grf_we, 1);
    chk("sb_grf_a3", grf_a3, 5);
    chk("sb_grf_wd", grf_wd, 32'h0000_1234);
    chk("sb_haz_until_commit", hazard_stall, 1);
    @(negedge clk);
    mdu_valid = 0;
    tick();
    chk("sb_haz_cleared", hazard_stall, 0);
    chk("sb_busy_cleared", mdu_busy, 0);

    // second issue while busy is ignored
    @(negedge clk);
    mdu_issue = 1; mdu_issue_a3 = 3; rd_a1 = 0;
    @(negedge clk);
    mdu_issue = 0;
    @(negedge clk);
    mdu_issue = 1; mdu_issue_a3 = 9;
    @(negedge clk);
    mdu_issue = 0; rd_we = 1; rd_a3 = 9;
    #1 chk("busy_issue_ignored", hazard_stall, 0);
    rd_a3 = 3;
    #1 chk("waw_hazard", hazard_stall, 1);
    @(negedge clk);
    mdu_valid = 1; mdu_a3 = 3;
    @(negedge clk);
    mdu_valid = 0;
    tick();
    chk("busy_ignored_done", mdu_busy, 0);
    chk("waw_cleared", hazard_stall, 0);

    // $0 destination: busy without a pending bit, accepted with no write
    @(negedge clk);
    rd_we = 0; rd_a3 = 0;
    mdu_issue = 1; mdu_issue_a3 = 0;
    tick();
    chk("zero_busy", mdu_busy, 1);
    @(negedge clk);
    mdu_issue = 0; rd_a1 = 0;
    #1 chk("zero_haz", hazard_stall, 0);
    @(negedge clk);
    mdu_valid = 1; mdu_a3 = 0;
    #1 chk("zero_ready", mdu_ready, 1);
    tick();
    chk("zero_grf_we", grf_we, 0);
    chk("zero_grf_a3", grf_a3, 0);
    @(negedge clk);
    mdu_valid = 0;
    tick();
    chk("zero_busy_clear", mdu_busy, 0);

    // randomized traffic against the behavioural model
    @(negedge clk);
    idle_inputs();
    reset = 0;
    @(negedge clk);
    reset = 1;
    m_denied = 0; m_out = 0; m_retire_due = 0; m_op_a3 = 0;
    m_we = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
    for (int r = 0; r < 32; r++) m_pend[r] = 0;
    drop = 0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      if (drop) mdu_valid = 0;
      pipe_we = ($urandom_range(0, 3) != 0);
      pipe_a3 = 5'($urandom_range(0, 7));
      pipe_wd = $urandom; pipe_pc = $urandom;
      mdu_issue = ($urandom_range(0, 5) == 0);
      mdu_issue_a3 = 5'($urandom_range(0, 7));
      if (!mdu_valid && $urandom_range(0, 3) == 0) begin
        mdu_valid = 1;
        mdu_a3 = (m_out && $urandom_range(0, 3) != 0) ? m_op_a3 : 5'($urandom_range(0, 7));
        mdu_wd = $urandom; mdu_pc = $urandom;
      end
      rd_a1 = 5'($urandom_range(0, 7)); rd_a2 = 5'($urandom_range(0, 7));
      rd_a3 = 5'($urandom_range(0, 7)); rd_we = 1'($urandom_range(0, 1));

      needs = pipe_we && (pipe_a3 != 0);
      e_frc = (m_denied > MW);
      e_rdy = mdu_valid && (e_frc || !needs);
      e_haz = (rd_a1 != 0 && m_pend[rd_a1]) || (rd_a2 != 0 && m_pend[rd_a2]) ||
              (rd_we && rd_a3 != 0 && m_pend[rd_a3]);
      #1;
      chk("rnd_ready", mdu_ready, e_rdy);
      chk("rnd_force", force_stall, e_frc);
      chk("rnd_hazard", hazard_stall, e_haz);

      hs = mdu_valid && e_rdy;
      if (hs) begin
        m_we = (mdu_a3 != 0); m_a3 = mdu_a3; m_wd = mdu_wd; m_pc = mdu_pc;
      end else if (needs && !e_frc) begin
        m_we = 1; m_a3 = pipe_a3; m_wd = pipe_wd; m_pc = pipe_pc;
      end else begin
        m_we = 0;
      end
      if (hs || !mdu_valid) m_denied = 0;
      else m_denied++;
      retire_now = m_retire_due;
      m_retire_due = hs && m_out && !retire_now;
      acc = mdu_issue && (!m_out || retire_now);
      if (retire_now) begin
        for (int r = 0; r < 32; r++) m_pend[r] = 0;
        m_out = 0;
      end
      if (acc) begin
        if (mdu_issue_a3 != 0) m_pend[mdu_issue_a3] = 1;
        m_out = 1;
        m_op_a3 = mdu_issue_a3;
      end
      drop = hs;

      tick();
      chk("rnd_grf_we", grf_we, m_we);
      chk("rnd_grf_a3", grf_a3, m_a3);
      chk("rnd_grf_wd", grf_wd, m_wd);
      chk("rnd_grf_pc", grf_pc, m_pc);
      chk("rnd_busy", mdu_busy, m_out);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
